// File: rtl/mem_access_unit_pkg.sv
// Shared load/store definitions for the MEM-stage access unit: funct3 encodings,
// FSM state type and small decode helpers.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    // Stores only come in signed-free sizes, so the unsigned encodings are illegal for them.
    function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
        if (is_store)
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        return ((funct3[1:0] == 2'b01) && lane[0]) ||
               ((funct3[1:0] == 2'b10) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-aligned req/ack data-memory bus between the load/store unit and data memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: store byte enables / replicated data, and load lane
// selection with sign or zero extension.
module lsu_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  store_funct3,
    input  logic [1:0]  store_lane,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_lane,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (store_funct3)
            F3_B: begin
                be    = 4'b0001 << store_lane;
                wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                be    = store_lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = rdata[{load_lane, 3'b000} +: 8];
    assign half_sel = rdata[{load_lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata;
        case (load_funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one outstanding req/ack access, stall while busy,
// timeout abort. Optional misaligned-access trap enabled by MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               MemReadM,
    input  logic               MemWriteM,
    input  logic [2:0]         Funct3M,
    input  logic [31:0]        ALUResultM,
    input  logic [31:0]        WriteDataM,
    output logic [31:0]        ReadDataM,
    output logic               StallM,
    output logic               BusErrM,
    output logic               MisalignM,
    mem_access_unit_if.master  dmem
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] busy_cnt;
    logic             req_q, we_q, timed_out_q;
    logic [31:0]      addr_q, wdata_q, read_data_q;
    logic [3:0]       be_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;

    logic             access, legal, misaligned, valid, timeout_hit;
    logic [3:0]       store_be;
    logic [31:0]      store_wdata, load_data;

    assign access = MemReadM | MemWriteM;
    assign legal  = is_legal(Funct3M, MemWriteM);
`ifdef MISALIGN_TRAP_EN
    assign misaligned = access & legal & is_misaligned(Funct3M, ALUResultM[1:0]);
`else
    assign misaligned = 1'b0;
`endif
    assign valid       = access & legal & ~misaligned;
    assign timeout_hit = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) & ~dmem.dmem_ack;

    lsu_align u_align (
        .store_funct3 (Funct3M),
        .store_lane   (ALUResultM[1:0]),
        .store_data   (WriteDataM),
        .be           (store_be),
        .wdata        (store_wdata),
        .load_funct3  (funct3_q),
        .load_lane    (lane_q),
        .rdata        (dmem.dmem_rdata),
        .load_data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid) state_next = BUSY;
            BUSY:    if (dmem.dmem_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are latched once on issue so the bus stays stable however long memory waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt    <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            timed_out_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            read_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    busy_cnt    <= '0;
                    timed_out_q <= 1'b0;
                    if (valid) begin
                        req_q    <= 1'b1;
                        we_q     <= MemWriteM;
                        addr_q   <= {ALUResultM[31:2], 2'b00};
                        be_q     <= MemWriteM ? store_be : 4'b1111;
                        wdata_q  <= store_wdata;
                        funct3_q <= Funct3M;
                        lane_q   <= ALUResultM[1:0];
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) read_data_q <= load_data;
                    end else if (timeout_hit) begin
                        req_q       <= 1'b0;
                        timed_out_q <= 1'b1;
                        read_data_q <= '0;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        StallM    = 1'b0;
        BusErrM   = 1'b0;
        MisalignM = 1'b0;
        case (state)
            IDLE: begin
                StallM    = valid;
                MisalignM = misaligned;
            end
            BUSY:    StallM  = 1'b1;
            DONE:    BusErrM = timed_out_q;
            default: ;
        endcase
    end

    assign ReadDataM       = read_data_q;
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// against a byte-lane arithmetic reference model. Honors MISALIGN_TRAP_EN.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM, MisalignM;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_read_data = 32'd0;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM),
        .MisalignM  (MisalignM),
        .dmem       (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: plain arithmetic on byte offsets, independent of RTL structure.
    function automatic logic exp_legal(input logic rd, input logic wr, input logic [2:0] f3);
        if (!(rd || wr)) return 1'b0;
        if (wr) return f3 <= 3'd2;
        return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    endfunction

    function automatic logic exp_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        int size;
        size = int'(f3) % 4;
        return ((size == 1) && (a % 2 != 0)) || ((size == 2) && (a % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (!wr) return 4'hF;
        case (int'(f3) % 4)
            0:       return 4'(1 << (a % 4));
            1:       return (a % 4 >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (int'(f3) % 4)
            0:       return (d & 32'hFF) * 32'h0101_0101;
            1:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) & 32'hFF;
        h = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return r;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One access end to end; waits<0 means memory never acks.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdata_in, input int waits);
        logic ok, mis, done;
        int   stall_cnt, req_cnt, exp_stall, exp_req;
        @(negedge clk);
        MemReadM     = rd;
        MemWriteM    = wr;
        Funct3M      = f3;
        ALUResultM   = a;
        WriteDataM   = wd;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = $urandom;
        mis  = exp_misaligned(f3, a);
        ok   = exp_legal(rd, wr, f3) && !mis;
        exp_stall = !ok ? 0 : (waits >= 0 ? waits + 2 : TIMEOUT + 1);
        exp_req   = !ok ? 0 : (waits >= 0 ? waits + 1 : TIMEOUT);
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < TIMEOUT + 8; cyc++) begin
            #1;
            checkOutput("misalign", {31'd0, MisalignM}, {31'd0, (cyc == 0) ? mis : 1'b0});
            if (bus.dmem_req) begin
                req_cnt++;
                checkOutput("addr", bus.dmem_addr, a & 32'hFFFF_FFFC);
                checkOutput("we", {31'd0, bus.dmem_we}, {31'd0, wr});
                checkOutput("be", {28'd0, bus.dmem_be}, {28'd0, exp_be(wr, f3, a)});
                if (wr) checkOutput("wdata", bus.dmem_wdata, exp_wdata(f3, wd));
                if (waits >= 0 && req_cnt == waits + 1) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = rdata_in;
                end
            end
            if (!StallM) begin
                done = 1'b1;
                break;
            end
            stall_cnt++;
            @(negedge clk);
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = $urandom;
        end
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("stall_cycles", stall_cnt, exp_stall);
        checkOutput("req_cycles", req_cnt, exp_req);
        checkOutput("buserr", {31'd0, BusErrM}, {31'd0, ok && waits < 0});
        if (ok && waits < 0)   exp_read_data = 32'd0;
        else if (ok && rd)     exp_read_data = exp_load(f3, a, rdata_in);
        checkOutput("read_data", ReadDataM, exp_read_data);
        @(negedge clk);
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        bus.dmem_ack = 1'($urandom % 2);
        #1;
        checkOutput("buserr_pulse", {31'd0, BusErrM}, 32'd0);
        checkOutput("req_idle", {31'd0, bus.dmem_req}, 32'd0);
        checkOutput("stall_idle", {31'd0, StallM}, 32'd0);
    endtask

    initial begin
        logic [2:0] rf3;
        int         kind, rwaits;
        reset        = 1'b1;
        MemReadM     = 1'b0;
        MemWriteM    = 1'b0;
        Funct3M      = 3'd0;
        ALUResultM   = 32'd0;
        WriteDataM   = 32'd0;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_read_data", ReadDataM, 32'd0);
        checkOutput("rst_stall", {31'd0, StallM}, 32'd0);
        checkOutput("rst_buserr", {31'd0, BusErrM}, 32'd0);
        checkOutput("rst_misalign", {31'd0, MisalignM}, 32'd0);
        checkOutput("rst_req", {31'd0, bus.dmem_req}, 32'd0);
        checkOutput("rst_we", {31'd0, bus.dmem_we}, 32'd0);
        checkOutput("rst_addr", bus.dmem_addr, 32'd0);
        checkOutput("rst_be", {28'd0, bus.dmem_be}, 32'd0);
        checkOutput("rst_wdata", bus.dmem_wdata, 32'd0);

        applyStimulus(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF_FF7F, 3);
        applyStimulus(1'b1, 1'b0, 3'd5, 32'h102, 32'd0, 32'h8001_1234, 1);
        applyStimulus(1'b0, 1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 32'd0, 2);
        applyStimulus(1'b0, 1'b1, 3'd0, 32'h201, 32'h0000_00A5, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 3'd1, 32'h300, 32'd0, 32'h1234_8765, 0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h400, 32'd0, 32'hCAFE_F00D, -1);
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h500, 32'd0, 32'h1111_1111, 0);
        applyStimulus(1'b0, 1'b1, 3'd4, 32'h500, 32'h5555_5555, 32'd0, 0);
        applyStimulus(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 32'h0BAD_CAFE, 0);
        applyStimulus(1'b1, 1'b0, 3'd1, 32'h603, 32'd0, 32'hFEDC_BA98, 1);

        for (int n = 0; n < 40; n++) begin
            kind   = int'($urandom_range(0, 4));
            rf3    = 3'($urandom_range(0, 7));
            rwaits = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            applyStimulus(kind inside {1, 2}, kind inside {3, 4}, rf3,
                          32'h1000 + $urandom_range(0, 255), $urandom, $urandom, rwaits);
        end

        // Reset lands in the second BUSY cycle; the ack that follows must be ignored.
        @(negedge clk);
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        Funct3M    = 3'd2;
        ALUResultM = 32'h700;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rstbusy_req1", {31'd0, bus.dmem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        MemReadM       = 1'b0;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h7777_7777;
        exp_read_data  = 32'd0;
        #1;
        checkOutput("rstbusy_req", {31'd0, bus.dmem_req}, 32'd0);
        checkOutput("rstbusy_stall", {31'd0, StallM}, 32'd0);
        checkOutput("rstbusy_addr", bus.dmem_addr, 32'd0);
        checkOutput("rstbusy_read_data", ReadDataM, exp_read_data);
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        checkOutput("late_ack_read_data", ReadDataM, exp_read_data);
        checkOutput("late_ack_buserr", {31'd0, BusErrM}, 32'd0);
        checkOutput("late_ack_req", {31'd0, bus.dmem_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
